seq_det_rr_ctrl: RTL and testbench
==================================

// Module: seq_det_rr_ctrl
// PURPOSE
//  Shares one overlapping "101" Mealy detector engine among NCH serial bit-stream requesters.
//  - A round-robin arbiter grants at most one channel per cycle.
//  - Each channel's detector state is saved per channel and restored on its next grant.
//  - A match is reported as a one-cycle pulse tagged with the channel index.
//  - Sits between the per-lane deserialisers and the event collector.
// PARAMETERS
//  NCH    4  number of requesting channels (2..16)
//  CW     2  channel index width, $clog2(NCH)
//  CNT_W  8  width of per-channel hit counter (DET_COUNT_EN only)
// PORTS
//  clk       in   1      clock
//  rst       in   1      reset; synchronous, active-high
//  ch_valid  in   NCH    channel i presents a bit
//  ch_bit    in   NCH    serial bit of channel i
//  ch_ready  out  NCH    one-hot grant; bit consumed when valid&ready (combinational)
//  ch_flush  in   NCH    clear channel i context to S0
//  det_valid out  1      registered pulse: "101" completed on det_ch
//  det_ch    out  CW     channel of the match; holds last value when det_valid=0
//  cnt_sel   in   CW     counter read select (DET_COUNT_EN)
//  cnt_val   out  CNT_W  registered hit count of channel cnt_sel (DET_COUNT_EN)
// BEHAVIOUR
//  Reset
//  - Sync, active-high, in effect during the rst cycle.
//  - All contexts <= S0; rr_ptr <= 0; det_valid <= 0; det_ch <= 0; counters <= 0; cnt_val <= 0.
//  - While rst=1, ch_ready=0 and no bit is consumed.
//  - A reset mid-stream discards partial matches on all channels.
//  Arbitration
//  - Search order is rr_ptr, rr_ptr+1, ... mod NCH. The first channel with valid & !flush is granted.
//  - On a grant, rr_ptr <= grant+1 mod NCH. With no candidate, no grant is made and rr_ptr holds.
//  - ch_ready depends only on ch_valid, ch_flush and registered state.
//  Detector FSM (per channel, on grant)
//  - S0: x=1 -> S1; x=0 -> S0.
//  - S1: x=1 -> S1; x=0 -> S2.
//  - S2: x=1 -> S1 with match; x=0 -> S0.
//  - Overlap is kept: after a match the next state is S1.
//  - The context value 2'b11 is illegal. It is treated as S0 with no match.
//  Output timing
//  - A match on the granting cycle gives det_valid=1 and det_ch=grant on the next cycle (latency 1).
//  - The next cycle can carry a match from a different grant, so back-to-back pulses are legal.
//  Flush
//  - ch_flush[i] writes S0 to context i.
//  - Flush wins over a same-cycle valid on that channel: ch_ready[i]=0 and the bit is not consumed.
//  - Flush never affects other channels or their grants.
//  Stalls
//  - A channel that is not granted keeps its context indefinitely.
//  - A channel that is not granted must hold ch_bit and ch_valid.
// CONFIGURATION
//  DET_COUNT_EN defined
//  - Each channel has a CNT_W-bit hit counter that increments on every match and saturates at 2^CNT_W-1.
//  - Counters are not cleared by flush.
//  - cnt_val <= count[cnt_sel] each cycle (1-cycle read latency).
//  DET_COUNT_EN undefined
//  - No counters are built, cnt_sel is ignored and cnt_val is tied to 0.
// STRUCTURE
//  Package seq_det_pkg
//  - det_state_t (2-bit): S0=2'b00, S1=2'b01, S2=2'b10.
//  - Function det_next(state, x) -> {next_state, match}.
//  Sub-module seq_det_rr_arb
//  - NCH-way round-robin arbiter: req, rr_ptr -> one-hot gnt, gnt_idx, gnt_any.
//  Top level: context register array, write-back mux, output registers, optional counters.
// TESTING
//  1. Channel 0 only, bits 1,0,1,0,1: det_valid pulses on the cycles after the 3rd and 5th grants, det_ch=0 (overlap).
//  2. NCH=4, all channels valid every cycle: grants 0,1,2,3,0,... with each channel granted exactly once per 4 cycles.
//  3. ch0 feeds 1,0; ch1 feeds 1 interleaved; then ch0 feeds 1: match tagged det_ch=0, ch1 context S1 is unaffected.
//  4. ch2 in S2; ch_flush[2] with ch_valid[2]=1 and bit 1 in the same cycle: ch_ready[2]=0, no match; later 1,0,1 is needed to match.
//  5. rst asserted while ch1 is in S2: the next bit 1 on ch1 gives no match; det_valid=0 and rr_ptr=0 after reset.
//  6. DET_COUNT_EN with CNT_W=2: 5 matches on ch3 give cnt_val=3 (saturated) with cnt_sel=3; other channels read 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: detector state encoding and the shared "101" Mealy step function
package seq_det_pkg;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10} det_state_t;
  // Returns {next_state, match}; the unused code 2'b11 behaves as S0.
  function automatic logic [2:0] det_next(input logic [1:0] s, input logic x);
    logic [1:0] n;
    n = x ? S1 : (s == S1 ? S2 : S0);
    return {n, (s == S2) && x};
  endfunction
endpackage

// File: rtl/seq_det_rr_arb.sv
// seq_det_rr_arb: NCH-way round-robin arbiter searching upward from ptr
module seq_det_rr_arb #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_any
);
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!gnt_any && req[(int'(ptr) + i) % NCH]) begin
        gnt[(int'(ptr) + i) % NCH] = 1'b1;
        gnt_idx = CW'((int'(ptr) + i) % NCH);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seq_det_rr_ctrl.sv
// seq_det_rr_ctrl: one "101" detector time-shared across NCH channels; DET_COUNT_EN adds per-channel hit counters
module seq_det_rr_ctrl
  import seq_det_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CW    = $clog2(NCH),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_valid,
  input  logic [NCH-1:0]   ch_bit,
  output logic [NCH-1:0]   ch_ready,
  input  logic [NCH-1:0]   ch_flush,
  output logic             det_valid,
  output logic [CW-1:0]    det_ch,
  input  logic [CW-1:0]    cnt_sel,
  output logic [CNT_W-1:0] cnt_val
);
  det_state_t       ctx_q [NCH];
  logic [CW-1:0]    ptr_q, ptr_d;
  logic             det_valid_q;
  logic [CW-1:0]    det_ch_q;
  logic [NCH-1:0]   req, gnt;
  logic [CW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [2:0]       step;
  det_state_t       nxt;
  logic             match;
  // Flushing channels never compete, and nothing is granted during reset.
  assign req = ch_valid & ~ch_flush & {NCH{~rst}};
  seq_det_rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
    .req(req), .ptr(ptr_q), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_any(gnt_any)
  );
  assign ch_ready  = gnt;
  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  always_comb begin
    step  = det_next(ctx_q[gnt_idx], ch_bit[gnt_idx]);
    nxt   = det_state_t'(step[2:1]);
    match = gnt_any && step[0];
    ptr_d = gnt_any ? (gnt_idx == CW'(NCH - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) ctx_q[i] <= S0;
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (ch_flush[i]) ctx_q[i] <= S0;
        else if (gnt[i]) ctx_q[i] <= nxt;
      ptr_q       <= ptr_d;
      det_valid_q <= match;
      if (match) det_ch_q <= gnt_idx;
    end
  end
`ifdef DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_val_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      cnt_val_q <= '0;
    end else begin
      if (match && cnt_q[gnt_idx] != '1) cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
      cnt_val_q <= (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
    end
  end
  assign cnt_val = cnt_val_q;
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_val = '0;
`endif
endmodule

// File: tb/tb_seq_det_rr_ctrl.sv
// tb_seq_det_rr_ctrl: directed vectors for the shared "101" detector and its arbiter
module tb_seq_det_rr_ctrl;
  localparam int NCH = 4, CW = 2, CNT_W = 2;
  logic clk, rst;
  logic [NCH-1:0] ch_valid, ch_bit, ch_ready, ch_flush;
  logic det_valid;
  logic [CW-1:0] det_ch, cnt_sel;
  logic [CNT_W-1:0] cnt_val;
  logic [NCH-1:0] rdy;
  int errors = 0, checks = 0, hits;
  seq_det_rr_ctrl #(.NCH(NCH), .CW(CW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_ready(ch_ready),
    .ch_flush(ch_flush), .det_valid(det_valid), .det_ch(det_ch), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // Apply one cycle of inputs, capture the combinational grant, then step past the edge.
  task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic [NCH-1:0] f);
    ch_valid = v; ch_bit = b; ch_flush = f;
    #1 rdy = ch_ready;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; ch_valid = '0; ch_bit = '0; ch_flush = '0; cnt_sel = '0;
    drive(4'b1111, 4'b1111, 4'b0000);
    check("rst_ready", rdy, 0);
    rst = 1'b0;
    check("rst_det_valid", det_valid, 0);
    check("rst_det_ch", det_ch, 0);
    check("rst_cnt_val", cnt_val, 0);
    // 1: overlapping 1,0,1,0,1 on ch0
    begin
      logic [4:0] bits, exp_dv;
      bits = 5'b10101; exp_dv = 5'b00101;
      for (int k = 0; k < 5; k++) begin
        drive(4'b0001, {3'b0, bits[4-k]}, 4'b0000);
        check($sformatf("t1_ready_%0d", k), rdy, 4'b0001);
        check($sformatf("t1_dv_%0d", k), det_valid, exp_dv[4-k]);
        if (exp_dv[4-k]) check($sformatf("t1_ch_%0d", k), det_ch, 0);
      end
    end
    // 2: fair rotation from rr_ptr=0 with all channels requesting
    rst = 1'b1; drive(4'b0000, 4'b0000, 4'b0000); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 4'b0000, 4'b0000);
      check($sformatf("t2_grant_%0d", k), rdy, 4'b0001 << (k % 4));
      check($sformatf("t2_dv_%0d", k), det_valid, 0);
    end
    // 3: interleaved contexts on ch0 and ch1
    drive(4'b0001, 4'b0001, 4'b0000);
    drive(4'b0010, 4'b0010, 4'b0000);
    drive(4'b0001, 4'b0000, 4'b0000);
    drive(4'b0010, 4'b0010, 4'b0000);
    check("t3_pre_dv", det_valid, 0);
    drive(4'b0001, 4'b0001, 4'b0000);
    check("t3_match_dv", det_valid, 1);
    check("t3_match_ch", det_ch, 0);
    drive(4'b0010, 4'b0000, 4'b0000);
    check("t3_ch1_s2_dv", det_valid, 0);
    drive(4'b0010, 4'b0010, 4'b0000);
    check("t3_ch1_dv", det_valid, 1);
    check("t3_ch1_ch", det_ch, 1);
    drive(4'b0000, 4'b0000, 4'b0000);
    check("t3_idle_dv", det_valid, 0);
    check("t3_hold_ch", det_ch, 1);
    // 4: flush beats a same-cycle bit on ch2; ch0 still granted
    drive(4'b0100, 4'b0100, 4'b0000);
    drive(4'b0100, 4'b0000, 4'b0000);
    drive(4'b0101, 4'b0100, 4'b0100);
    check("t4_flush_ready", rdy, 4'b0001);
    check("t4_flush_dv", det_valid, 0);
    drive(4'b0100, 4'b0100, 4'b0000);
    check("t4_after1_dv", det_valid, 0);
    drive(4'b0100, 4'b0000, 4'b0000);
    check("t4_after0_dv", det_valid, 0);
    drive(4'b0100, 4'b0100, 4'b0000);
    check("t4_rematch_dv", det_valid, 1);
    check("t4_rematch_ch", det_ch, 2);
    // 5: reset with ch1 in S2 discards the partial match
    drive(4'b0010, 4'b0010, 4'b0000);
    drive(4'b0010, 4'b0000, 4'b0000);
    rst = 1'b1;
    drive(4'b0010, 4'b0010, 4'b0000);
    check("t5_rst_ready", rdy, 0);
    check("t5_rst_dv", det_valid, 0);
    check("t5_rst_ch", det_ch, 0);
    rst = 1'b0;
    drive(4'b1111, 4'b0000, 4'b0000);
    check("t5_ptr0_grant", rdy, 4'b0001);
    drive(4'b0010, 4'b0010, 4'b0000);
    check("t5_ch1_ready", rdy, 4'b0010);
    check("t5_ch1_dv", det_valid, 0);
    // 6: five matches on ch3, counter saturation
    hits = 0;
    for (int k = 0; k < 11; k++) begin
      drive(4'b1000, (k % 2 == 0) ? 4'b1000 : 4'b0000, 4'b0000);
      if (det_valid && det_ch == 2'd3) hits++;
    end
    check("t6_hits", hits, 5);
    for (int s = 0; s < NCH; s++) begin
      cnt_sel = CW'(s);
      drive(4'b0000, 4'b0000, 4'b0000);
`ifdef DET_COUNT_EN
      check($sformatf("t6_cnt_%0d", s), cnt_val, (s == 3) ? 3 : 0);
`else
      check($sformatf("t6_cnt_%0d", s), cnt_val, 0);
`endif
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
